// File: rtl/ack_bus_initiator.sv
// ack_bus_initiator: module-side driver for the shared open-drain ACK bus.
// Queues local acks, arbitrates by lowest wired ID, and handshakes with the central arbiter.
`default_nettype none

module ack_bus_initiator #(
  parameter logic [1:0] SOURCE_ID      = 2'b00,
  parameter int         PEND_W         = 3,
  parameter int         TIMEOUT_CYCLES = 64,
  parameter int         TO_W           = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ack_req_i,
  input  logic              ack_valid_n_bus,
  input  logic [1:0]        ack_id_bus,
  input  logic              ack_ready_i,
  output logic              ack_valid_n_oe,
  output logic [1:0]        ack_id_oe,
  output logic              req_o,
  output logic              busy,
  output logic [PEND_W-1:0] pending_cnt,
  output logic              ack_done,
  output logic              ack_timeout,
  output logic              ack_overflow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } state_t;

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam bit                TO_EN    = (TIMEOUT_CYCLES != 0);

  state_t          state;
  logic [TO_W-1:0] to_cnt;

  logic in_assert;
  logic grant;
  logic expire;
  logic dec;
  logic full;
  logic accept;
  logic drop;

  // The valid line and the low ID bit are observed only by the arbiter side.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{ack_valid_n_bus, ack_id_bus[0]};

  always_comb begin
    in_assert = (state == ASSERT);
    grant     = in_assert & ack_ready_i;
    // Grant takes precedence over an expiring timer on the same edge.
    expire    = in_assert & TO_EN & (to_cnt == TO_LAST) & ~ack_ready_i;
    dec       = grant | expire;
    full      = (pending_cnt == PEND_MAX);
    accept    = ack_req_i & (~full | dec);
    drop      = ack_req_i & full & ~dec;
  end

  assign req_o          = in_assert;
  assign busy           = (state != IDLE);
  assign ack_valid_n_oe = in_assert;
  // Bit 1 depends only on state; bit 0 yields if a lower ID already owns bit 1.
  assign ack_id_oe[1]   = in_assert & ~SOURCE_ID[1];
  assign ack_id_oe[0]   = in_assert & ~SOURCE_ID[0] & (ack_id_bus[1] == SOURCE_ID[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      to_cnt       <= '0;
      pending_cnt  <= '0;
      ack_done     <= 1'b0;
      ack_timeout  <= 1'b0;
      ack_overflow <= 1'b0;
    end else begin
      ack_done     <= grant;
      ack_timeout  <= expire;
      ack_overflow <= drop;

      if (accept && !dec) begin
        pending_cnt <= pending_cnt + 1'b1;
      end else if (dec && !accept) begin
        pending_cnt <= pending_cnt - 1'b1;
      end

      case (state)
        IDLE: begin
          to_cnt <= '0;
          if ((pending_cnt != '0) || ack_req_i) begin
            state <= ASSERT;
          end
        end
        ASSERT: begin
          if (dec) begin
            state  <= GAP;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        GAP: begin
          to_cnt <= '0;
          state  <= (pending_cnt != '0) ? ASSERT : IDLE;
        end
        default: begin
          state  <= IDLE;
          to_cnt <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ack_bus_initiator.sv
// tb_ack_bus_initiator: two initiators (IDs 01 and 10) on a pull-up wired bus model.
`default_nettype none

module tb_ack_bus_initiator;

  localparam int S_I = 0;
  localparam int S_A = 1;
  localparam int S_G = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic req_a, rdy_a, req_b, rdy_b;

  logic       a_valid_oe, b_valid_oe;
  logic [1:0] a_id_oe, b_id_oe;
  logic       a_req, b_req, a_busy, b_busy;
  logic [2:0] a_pend, b_pend;
  logic       a_done, b_done, a_to, b_to, a_ovf, b_ovf;

  logic       bus_valid_n, bus_id1, bus_id0;
  logic [1:0] bus_id;
  assign bus_valid_n = ~(a_valid_oe | b_valid_oe);
  assign bus_id1     = ~(a_id_oe[1] | b_id_oe[1]);
  assign bus_id0     = ~(a_id_oe[0] | b_id_oe[0]);
  assign bus_id      = {bus_id1, bus_id0};

  always #5 clk = ~clk;

  ack_bus_initiator #(.SOURCE_ID(2'b01), .PEND_W(3), .TIMEOUT_CYCLES(4), .TO_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .ack_req_i(req_a), .ack_valid_n_bus(bus_valid_n),
    .ack_id_bus({bus_id1, bus_id0}), .ack_ready_i(rdy_a), .ack_valid_n_oe(a_valid_oe),
    .ack_id_oe(a_id_oe), .req_o(a_req), .busy(a_busy), .pending_cnt(a_pend),
    .ack_done(a_done), .ack_timeout(a_to), .ack_overflow(a_ovf)
  );

  ack_bus_initiator #(.SOURCE_ID(2'b10), .PEND_W(3), .TIMEOUT_CYCLES(0), .TO_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .ack_req_i(req_b), .ack_valid_n_bus(bus_valid_n),
    .ack_id_bus({bus_id1, bus_id0}), .ack_ready_i(rdy_b), .ack_valid_n_oe(b_valid_oe),
    .ack_id_oe(b_id_oe), .req_o(b_req), .busy(b_busy), .pending_cnt(b_pend),
    .ack_done(b_done), .ack_timeout(b_to), .ack_overflow(b_ovf)
  );

  // {valid_oe, id_oe[1:0], req_o, busy, pending_cnt[2:0], done, timeout, overflow}
  typedef struct packed {
    logic        req;
    logic        rdy;
    logic [10:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [10:0] sb[$];
  int          n_chk  = 0;
  int          n_pass = 0;

  function automatic vec_t mk(input logic req, input logic rdy, input int st,
                              input int pend, input logic done, input logic to);
    vec_t v;
    logic a;
    a     = (st == S_A);
    v.req = req;
    v.rdy = rdy;
    v.exp = {a, a, 1'b0, a, (st != S_I), 3'(pend), done, to, 1'b0};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] exp_v, obs_v;
    int          dones;

    rst_n = 1'b0;
    req_a = 1'b0; rdy_a = 1'b0; req_b = 1'b0; rdy_b = 1'b0;
    cyc(); cyc();
    check("reset_a_outputs", {a_valid_oe, a_id_oe, a_req, a_busy, a_pend, a_done, a_to, a_ovf}, 0);
    check("reset_b_outputs", {b_valid_oe, b_id_oe, b_req, b_busy, b_pend, b_done, b_to, b_ovf}, 0);
    rst_n = 1'b1;
    cyc();

    // Single ack: grant in the third ASSERT cycle
    tbl.push_back(mk(1, 0, S_A, 1, 0, 0));
    tbl.push_back(mk(0, 0, S_A, 1, 0, 0));
    tbl.push_back(mk(0, 0, S_A, 1, 0, 0));
    tbl.push_back(mk(0, 1, S_G, 0, 1, 0));
    tbl.push_back(mk(0, 0, S_I, 0, 0, 0));
    // Queueing: three back-to-back requests, then grant every ASSERT
    tbl.push_back(mk(1, 0, S_A, 1, 0, 0));
    tbl.push_back(mk(1, 0, S_A, 2, 0, 0));
    tbl.push_back(mk(1, 0, S_A, 3, 0, 0));
    tbl.push_back(mk(0, 1, S_G, 2, 1, 0));
    tbl.push_back(mk(0, 1, S_A, 2, 0, 0));
    tbl.push_back(mk(0, 1, S_G, 1, 1, 0));
    tbl.push_back(mk(0, 1, S_A, 1, 0, 0));
    tbl.push_back(mk(0, 1, S_G, 0, 1, 0));
    tbl.push_back(mk(0, 1, S_I, 0, 0, 0));
    // Timeout after four ASSERT cycles
    tbl.push_back(mk(1, 0, S_A, 1, 0, 0));
    tbl.push_back(mk(0, 0, S_A, 1, 0, 0));
    tbl.push_back(mk(0, 0, S_A, 1, 0, 0));
    tbl.push_back(mk(0, 0, S_A, 1, 0, 0));
    tbl.push_back(mk(0, 0, S_G, 0, 0, 1));
    tbl.push_back(mk(0, 0, S_I, 0, 0, 0));
    // Ready on the fourth cycle beats the timeout
    tbl.push_back(mk(1, 0, S_A, 1, 0, 0));
    tbl.push_back(mk(0, 0, S_A, 1, 0, 0));
    tbl.push_back(mk(0, 0, S_A, 1, 0, 0));
    tbl.push_back(mk(0, 0, S_A, 1, 0, 0));
    tbl.push_back(mk(0, 1, S_G, 0, 1, 0));
    tbl.push_back(mk(0, 0, S_I, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      req_a = tbl[i].req;
      rdy_a = tbl[i].rdy;
      sb.push_back(tbl[i].exp);
      cyc();
      req_a = 1'b0;
      rdy_a = 1'b0;
      obs_v = {a_valid_oe, a_id_oe, a_req, a_busy, a_pend, a_done, a_to, a_ovf};
      if (sb.size() == 0) begin
        check($sformatf("scoreboard_empty_%0d", i), 1, 0);
      end else begin
        exp_v = sb.pop_front();
        check($sformatf("vector_%0d", i), obs_v, exp_v);
      end
    end

    // Contention: 01 wins, 10 backs off bit 0, then 10 takes the bus after 01's GAP
    req_a = 1'b1; req_b = 1'b1;
    cyc();
    req_a = 1'b0; req_b = 1'b0;
    check("cont_bus_id_01", bus_id, 2'b01);
    check("cont_bus_valid_low", bus_valid_n, 1'b0);
    check("cont_b_id_oe", b_id_oe, 2'b00);
    check("cont_a_id_oe", a_id_oe, 2'b10);
    rdy_a = 1'b1;
    cyc();
    rdy_a = 1'b0;
    check("cont_a_done", a_done, 1'b1);
    check("cont_a_released", {a_valid_oe, a_id_oe, a_req}, 0);
    check("cont_bus_id_10", bus_id, 2'b10);
    check("cont_b_id_oe_after", b_id_oe, 2'b01);
    cyc();
    check("cont_a_idle", a_busy, 1'b0);
    rdy_b = 1'b1;
    cyc();
    rdy_b = 1'b0;
    check("cont_b_done", {b_done, b_busy, b_req, b_pend}, {1'b1, 1'b1, 1'b0, 3'd0});
    cyc();
    check("cont_b_idle", b_busy, 1'b0);

    // Overflow: u_b never times out, so it holds ASSERT while requests pile up
    for (int i = 1; i <= 8; i++) begin
      req_b = 1'b1;
      cyc();
      req_b = 1'b0;
      if (i == 7) check("ovf_count_7", {b_pend, b_ovf}, {3'd7, 1'b0});
    end
    check("ovf_pulse", {b_pend, b_ovf}, {3'd7, 1'b1});
    req_b = 1'b1; rdy_b = 1'b1;
    cyc();
    req_b = 1'b0;
    check("ovf_req_with_grant", {b_pend, b_done, b_ovf}, {3'd7, 1'b1, 1'b0});
    repeat (16) cyc();
    rdy_b = 1'b0;
    check("ovf_drained", {b_busy, b_pend}, 0);

    // Asynchronous reset in the middle of ASSERT
    req_a = 1'b1;
    cyc();
    req_a = 1'b0;
    cyc();
    check("rst_pre_assert", {a_valid_oe, a_req, a_pend}, {1'b1, 1'b1, 3'd1});
    #3 rst_n = 1'b0;
    #1;
    check("rst_async_release", {a_valid_oe, a_id_oe, a_req, a_busy, a_pend}, 0);
    cyc();
    rst_n = 1'b1;
    rdy_a = 1'b1;
    dones = 0;
    repeat (4) begin
      cyc();
      if (a_done) dones++;
    end
    rdy_a = 1'b0;
    check("rst_no_spurious_done", dones, 0);
    check("rst_stays_idle", {a_busy, a_pend}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ack_bus_initiator.md
Name: ack_bus_initiator

Overview:
- Module-side driver for the shared open-drain ACK bus. One instance sits in each of the ctrl, aes, sha and mem modules.
- Queues local acknowledge events and drives ack_valid_n and ack_id onto the wired bus. The bus resolves to the lowest ID.
- Raises the sideband request to the central arbiter and holds until that arbiter returns a one-hot ready.
- Adds retry spacing, a bounded pending queue and a watchdog timeout.

Parameters:
- SOURCE_ID, 2'b00, this module's bus ID (mem=00, sha=01, aes=10, ctrl=11); lower ID wins.
- PEND_W, 3, pending-counter width; queue capacity = 2^PEND_W-1 (7).
- TIMEOUT_CYCLES, 64, cycles in ASSERT without ready before the ack is abandoned; 0 disables the timeout.
- TO_W, 8, timeout counter width; must satisfy TIMEOUT_CYCLES < 2^TO_W.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ack_req_i  input  1  one-cycle pulse from module logic; queues one ack.
- ack_valid_n_bus  input  1  resolved bus valid; 0 = some source is acking.
- ack_id_bus  input  2  resolved bus ID.
- ack_ready_i  input  1  grant from the arbiter for this source.
- ack_valid_n_oe  output  1  1 = pull the ack_valid_n line low.
- ack_id_oe  output  2  per-bit pull-low enables for the ack_id lines.
- req_o  output  1  sideband request to the arbiter (its req_<src>).
- busy  output  1  FSM is not IDLE.
- pending_cnt  output  PEND_W  queued acks, including the one in flight.
- ack_done  output  1  one-cycle pulse: the ack was granted.
- ack_timeout  output  1  one-cycle pulse: the ack was abandoned.
- ack_overflow  output  1  one-cycle pulse: ack_req_i was dropped because the queue was full.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pending_cnt=0, timeout counter=0.
  - All outputs are 0, so every oe is released. Release is immediate, with no clock needed; this applies to reset mid-transaction too.
- States: IDLE, ASSERT, GAP.
- IDLE:
  - If pending_cnt>0, or ack_req_i=1, go to ASSERT next cycle.
  - Latency: ack_req_i at edge N puts the bus drive in place from N+1.
- ASSERT:
  - req_o=1 and ack_valid_n_oe=1.
  - ack_id_oe[1]=~SOURCE_ID[1].
  - ack_id_oe[0]=~SOURCE_ID[0] & (ack_id_bus[1]==SOURCE_ID[1]). This is combinational from the bus and yields minimum-ID resolution. Bit 1 must not depend on bus inputs, so there is no loop.
  - The timeout counter increments every ASSERT cycle.
- ASSERT, grant: ack_ready_i=1 at an edge ->
  - ack_done pulses next cycle;
  - pending_cnt decrements;
  - go to GAP.
- ASSERT, timeout (TIMEOUT_CYCLES!=0): counter reaches TIMEOUT_CYCLES-1 with no ready ->
  - ack_timeout pulses;
  - pending_cnt decrements, dropping that ack;
  - go to GAP.
- ASSERT, grant and timeout on the same edge: the grant wins, so ack_done pulses and ack_timeout does not.
- GAP:
  - Exactly one cycle with all oe=0 and req_o=0, so lower-priority sources can win.
  - Then go to ASSERT if pending_cnt>0, else IDLE.
  - The timeout counter clears on entering GAP.
- ack_ready_i is ignored outside ASSERT.
- Outputs req_o, busy and ack_valid_n_oe are registered state decodes.
- pending_cnt update each edge: +1 on an accepted ack_req_i, -1 on grant or timeout.
  - If both happen on the same edge, the count is unchanged.
  - The counter never wraps.
- Overflow: ack_req_i while pending_cnt==2^PEND_W-1 with no decrement on that edge -> the request is dropped, ack_overflow pulses, and the count holds.
  - If a decrement happens on the same edge, the request is accepted.
- busy = (state!=IDLE).
- ack_done, ack_timeout and ack_overflow are registered single-cycle pulses. They may coincide, e.g. overflow together with done.

Test Plan:
- Single ack, SOURCE_ID=01: pulse ack_req_i at cycle 0.
  - ASSERT from cycle 1: ack_valid_n_oe=1, ack_id_oe=2'b10, req_o=1.
  - Drive ack_ready_i at cycle 3: ack_done at cycle 4, GAP at cycle 4, IDLE at cycle 5, pending_cnt 1->0.
- Contention: instances with IDs 01 and 10 both assert on a pull-up bus model.
  - The bus resolves to 01, and ID 10 shows ack_id_oe[0]=0.
  - After 01 is granted and passes GAP, the bus resolves to 10 and it is granted.
- Queueing: 3 ack_req_i pulses within 3 cycles, ready granted each ASSERT cycle.
  - pending_cnt peaks at 3.
  - Three ack_done pulses, each separated by a GAP cycle, then IDLE.
- Timeout: TIMEOUT_CYCLES=4, no ready.
  - ack_timeout after 4 ASSERT cycles, pending_cnt 1->0, GAP, then IDLE.
  - Repeat with ready on the 4th cycle: ack_done and no ack_timeout.
- Overflow: hold in ASSERT, issue 8 requests.
  - pending_cnt saturates at 7 and the 8th produces ack_overflow.
  - A request coincident with a grant at count 7 is accepted and the count stays 7.
- Reset mid-ASSERT: deassert rst_n asynchronously between edges.
  - All oe/req_o drop to 0 in the same timestep and pending_cnt=0.
  - After release, no spurious ack_done.
